// File: rtl/rcv_ctrl_uart1.sv
// -----------------------------------------------------------------------------
// rcv_ctrl_uart1 -- UART command-frame receiver and control-register block.
//
// Pulls bytes from a UART receive FIFO (one byte per two cycles at most),
// parses frames of the form
//   0xEB 0x90 CMD LEN payload[LEN] CHK,   CHK = (CMD + LEN + payload) mod 256
// and applies accepted commands to the control outputs:
//   CMD 0x01, LEN 2 : baud_word <= {b0,b1}, latch_baud strobe
//   CMD 0x02, LEN 1 : self_loop <= b0[0]
//   CMD 0x03, LEN 2 : ch_mask   <= {b0,b1}[NUM_PULSE-1:0]
// Rejected frames strobe cmd_err and bump the saturating err_cnt.
//
// Parameters
//   NUM_PULSE   width of ch_mask (at most 16)
//   MAX_LEN     largest LEN accepted before the frame is rejected
//   TIMEOUT_CYC inter-byte timeout in clk cycles (timer build only)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   rx_fifo_empty  receive FIFO empty flag
//   rx_fifo_ren    read strobe to the receive FIFO
//   rx_fifo_rdata  FIFO read data, valid the cycle after rx_fifo_ren
//   latch_baud     one-cycle strobe: baud_word has just been updated
//   baud_word      UART baud divisor
//   self_loop      UART loopback select
//   ch_mask        pulse-channel enable mask
//   cmd_ok         one-cycle strobe: frame accepted
//   cmd_err        one-cycle strobe: frame rejected
//   err_cnt        rejected-frame count, saturating at 255
//
// Build option
//   RCV_CTRL_TIMEOUT_EN  when defined, a mid-frame gap of TIMEOUT_CYC cycles
//                        without a sampled byte aborts the frame as an error.
//                        When undefined there is no timer and the parser
//                        waits indefinitely mid-frame.
// -----------------------------------------------------------------------------
module rcv_ctrl_uart1 #(
  parameter int NUM_PULSE   = 12,
  parameter int MAX_LEN     = 8,
  parameter int TIMEOUT_CYC = 1105920
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_fifo_empty,
  output logic                 rx_fifo_ren,
  input  logic [7:0]           rx_fifo_rdata,
  output logic                 latch_baud,
  output logic [15:0]          baud_word,
  output logic                 self_loop,
  output logic [NUM_PULSE-1:0] ch_mask,
  output logic                 cmd_ok,
  output logic                 cmd_err,
  output logic [7:0]           err_cnt
);

  localparam logic [7:0] SYNC0    = 8'hEB;
  localparam logic [7:0] SYNC1    = 8'h90;
  localparam logic [7:0] CMD_BAUD = 8'h01;
  localparam logic [7:0] CMD_LOOP = 8'h02;
  localparam logic [7:0] CMD_MASK = 8'h03;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK,
    S_EXEC
  } state_t;

  state_t      state;
  logic        rd_vld;     // rx_fifo_rdata holds a fresh byte this cycle
  logic [7:0]  cmd_q;
  logic [7:0]  len_q;
  logic [7:0]  sum_q;      // running checksum over CMD, LEN and payload
  logic [7:0]  idx_q;      // payload byte index
  logic [7:0]  b0_q;
  logic [7:0]  b1_q;
  logic        exec_ok;
  logic [7:0]  err_inc;
  logic [15:0] pay_word;
  logic        timeout;

  // Only the three known CMD/LEN pairings are executable.
  assign exec_ok = ((cmd_q == CMD_BAUD) && (len_q == 8'd2)) ||
                   ((cmd_q == CMD_LOOP) && (len_q == 8'd1)) ||
                   ((cmd_q == CMD_MASK) && (len_q == 8'd2));

  assign err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  assign pay_word = {b0_q, b1_q};

`ifdef RCV_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] timer;

  // Counts idle cycles mid-frame; fires on the TIMEOUT_CYC-th idle cycle.
  assign timeout = (state != S_HDR0) && (state != S_EXEC) && !rd_vld &&
                   (timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if ((state == S_HDR0) || rd_vld || timeout) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  // No timer in this build; the expression folds to constant 0.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_HDR0;
      rx_fifo_ren <= 1'b0;
      rd_vld      <= 1'b0;
      latch_baud  <= 1'b0;
      baud_word   <= 16'd0;
      self_loop   <= 1'b0;
      ch_mask     <= '1;
      cmd_ok      <= 1'b0;
      cmd_err     <= 1'b0;
      err_cnt     <= 8'd0;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      idx_q       <= 8'd0;
      b0_q        <= 8'd0;
      b1_q        <= 8'd0;
    end else begin
      // NOTE: every register here uses <= so all next-state terms read the
      // values from before this edge, regardless of statement order.
      // A read is outstanding while rx_fifo_ren is high; the byte lands one
      // cycle later, so reads are issued at most every other cycle.
      rx_fifo_ren <= !rx_fifo_empty && !rx_fifo_ren;
      rd_vld      <= rx_fifo_ren;
      latch_baud  <= 1'b0;
      cmd_ok      <= 1'b0;
      cmd_err     <= 1'b0;

      if (timeout) begin
        state   <= S_HDR0;
        cmd_err <= 1'b1;
        err_cnt <= err_inc;
      end else begin
        case (state)
          S_HDR0: begin
            if (rd_vld && (rx_fifo_rdata == SYNC0)) state <= S_HDR1;
          end

          S_HDR1: begin
            if (rd_vld) begin
              if (rx_fifo_rdata == SYNC1)      state <= S_CMD;
              else if (rx_fifo_rdata != SYNC0) state <= S_HDR0;
            end
          end

          S_CMD: begin
            if (rd_vld) begin
              cmd_q <= rx_fifo_rdata;
              sum_q <= rx_fifo_rdata;
              state <= S_LEN;
            end
          end

          S_LEN: begin
            if (rd_vld) begin
              len_q <= rx_fifo_rdata;
              sum_q <= sum_q + rx_fifo_rdata;
              idx_q <= 8'd0;
              if (rx_fifo_rdata > 8'(MAX_LEN)) begin
                state   <= S_HDR0;
                cmd_err <= 1'b1;
                err_cnt <= err_inc;
              end else if (rx_fifo_rdata == 8'd0) begin
                state <= S_CHK;
              end else begin
                state <= S_DATA;
              end
            end
          end

          S_DATA: begin
            if (rd_vld) begin
              sum_q <= sum_q + rx_fifo_rdata;
              // Only the first two payload bytes feed any command.
              if (idx_q == 8'd0) b0_q <= rx_fifo_rdata;
              if (idx_q == 8'd1) b1_q <= rx_fifo_rdata;
              idx_q <= idx_q + 8'd1;
              if (idx_q == len_q - 8'd1) state <= S_CHK;
            end
          end

          S_CHK: begin
            if (rd_vld) begin
              if (rx_fifo_rdata == sum_q) begin
                state <= S_EXEC;
              end else begin
                state   <= S_HDR0;
                cmd_err <= 1'b1;
                err_cnt <= err_inc;
              end
            end
          end

          S_EXEC: begin
            state <= S_HDR0;
            if (exec_ok) begin
              cmd_ok <= 1'b1;
              case (cmd_q)
                CMD_BAUD: begin
                  baud_word  <= pay_word;
                  latch_baud <= 1'b1;
                end
                CMD_LOOP: self_loop <= b0_q[0];
                default:  ch_mask   <= pay_word[NUM_PULSE-1:0];
              endcase
            end else begin
              cmd_err <= 1'b1;
              err_cnt <= err_inc;
            end
          end

          default: state <= S_HDR0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rcv_ctrl_uart1.sv
// -----------------------------------------------------------------------------
// tb_rcv_ctrl_uart1 -- scoreboard bench for rcv_ctrl_uart1.
//
// A behavioural FIFO feeds directed byte frames to the DUT. Each frame's
// hand-computed outcome (strobe kind, register values, err_cnt and latency
// from its trigger byte) is queued; a monitor on the falling edge pops and
// compares whenever cmd_ok or cmd_err is seen.
// -----------------------------------------------------------------------------
module tb_rcv_ctrl_uart1;

  localparam int NP   = 12;
  localparam int MAXL = 8;
  localparam int TOC  = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_fifo_empty;
  logic          rx_fifo_ren;
  logic [7:0]    rx_fifo_rdata;
  logic          latch_baud;
  logic [15:0]   baud_word;
  logic          self_loop;
  logic [NP-1:0] ch_mask;
  logic          cmd_ok;
  logic          cmd_err;
  logic [7:0]    err_cnt;

  rcv_ctrl_uart1 #(
    .NUM_PULSE  (NP),
    .MAX_LEN    (MAXL),
    .TIMEOUT_CYC(TOC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_ren  (rx_fifo_ren),
    .rx_fifo_rdata(rx_fifo_rdata),
    .latch_baud   (latch_baud),
    .baud_word    (baud_word),
    .self_loop    (self_loop),
    .ch_mask      (ch_mask),
    .cmd_ok       (cmd_ok),
    .cmd_err      (cmd_err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    bit            ok;
    bit            latch;
    logic [15:0]   baud;
    bit            sl;
    logic [NP-1:0] mask;
    logic [7:0]    errc;
    int            trig;   // index of the byte the outcome is timed from
    int            lat;    // required cycles from its pop; -1 = untimed
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         pop_cyc[int];
  int         n_pushed = 0;
  int         n_popped = 0;
  int         cyc      = 0;
  int         checks   = 0;
  int         errors   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send_frame(input byte_q_t f);
    foreach (f[i]) begin
      fifo_q.push_back(f[i]);
      n_pushed++;
    end
    rx_fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push_exp(input bit ok, input bit latch, input logic [15:0] baud,
                          input bit sl, input logic [NP-1:0] mask, input logic [7:0] errc,
                          input int trig, input int lat);
    exp_t e;
    e.ok = ok; e.latch = latch; e.baud = baud; e.sl = sl;
    e.mask = mask; e.errc = errc; e.trig = trig; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Bounded wait for the FIFO to empty and every queued outcome to appear.
  task automatic drain();
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    check("outcomes_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // FIFO model: a read strobe in cycle t presents data during cycle t+1.
  always @(posedge clk) begin
    if (rx_fifo_ren === 1'b1) begin
      #1;
      check("read_when_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) begin
        rx_fifo_rdata = fifo_q.pop_front();
        pop_cyc[n_popped] = cyc;
        n_popped++;
      end
      rx_fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Monitor: compares each strobe against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n === 1'b1) begin
      if (latch_baud && !cmd_ok) check("latch_alone", 32'(latch_baud), 32'd0);
      if (cmd_ok || cmd_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, cmd_ok, cmd_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_ok",     32'(cmd_ok),     32'(e.ok));
          check("cmd_err",    32'(cmd_err),    32'(!e.ok));
          check("latch_baud", 32'(latch_baud), 32'(e.latch));
          check("baud_word",  32'(baud_word),  32'(e.baud));
          check("self_loop",  32'(self_loop),  32'(e.sl));
          check("ch_mask",    32'(ch_mask),    32'(e.mask));
          check("err_cnt",    32'(err_cnt),    32'(e.errc));
          if (e.lat >= 0) check("latency", 32'(cyc - pop_cyc[e.trig]), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t f;
    int      t;
    logic [7:0] ec;

    rst_n         = 1'b0;
    rx_fifo_empty = 1'b1;
    rx_fifo_rdata = 8'd0;
    #12;
    check("rst_ren",     32'(rx_fifo_ren), 32'd0);
    check("rst_latch",   32'(latch_baud),  32'd0);
    check("rst_baud",    32'(baud_word),   32'd0);
    check("rst_loop",    32'(self_loop),   32'd0);
    check("rst_mask",    32'(ch_mask),     32'hFFF);
    check("rst_ok",      32'(cmd_ok),      32'd0);
    check("rst_err",     32'(cmd_err),     32'd0);
    check("rst_err_cnt", 32'(err_cnt),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Valid baud command.
    f = '{8'hEB, 8'h90, 8'h01, 8'h02, 8'h00, 8'h60, 8'h63};
    send_frame(f); push_exp(1, 1, 16'h0060, 0, 12'hFFF, 8'd0, n_pushed - 1, 3);
    drain();

    // Bad checksum: rejected two cycles after CHK, baud untouched.
    f = '{8'hEB, 8'h90, 8'h01, 8'h02, 8'h00, 8'h60, 8'h64};
    send_frame(f); push_exp(0, 0, 16'h0060, 0, 12'hFFF, 8'd1, n_pushed - 1, 2);
    drain();

    // Resync through junk and a repeated 0xEB, then loopback on.
    f = '{8'h55, 8'hEB, 8'hEB, 8'h90, 8'h02, 8'h01, 8'h01, 8'h04};
    send_frame(f); push_exp(1, 0, 16'h0060, 1, 12'hFFF, 8'd1, n_pushed - 1, 3);
    drain();

    // LEN 9 > MAX_LEN: rejected right at the LEN byte.
    f = '{8'hEB, 8'h90, 8'h03, 8'h09};
    send_frame(f); push_exp(0, 0, 16'h0060, 1, 12'hFFF, 8'd2, n_pushed - 1, 2);
    drain();

    // Mask cleared, then set to all ones (upper nibble of 0x0FFF dropped).
    f = '{8'hEB, 8'h90, 8'h03, 8'h02, 8'h00, 8'h00, 8'h05};
    send_frame(f); push_exp(1, 0, 16'h0060, 1, 12'h000, 8'd2, n_pushed - 1, 3);
    drain();
    f = '{8'hEB, 8'h90, 8'h03, 8'h02, 8'h0F, 8'hFF, 8'h13};
    send_frame(f); push_exp(1, 0, 16'h0060, 1, 12'hFFF, 8'd2, n_pushed - 1, 3);
    drain();

    // Unknown CMD with LEN 0: reaches EXEC, then rejected.
    f = '{8'hEB, 8'h90, 8'h07, 8'h00, 8'h07};
    send_frame(f); push_exp(0, 0, 16'h0060, 1, 12'hFFF, 8'd3, n_pushed - 1, 3);
    drain();

    // Loopback CMD with LEN 2: mismatch, self_loop stays 1.
    f = '{8'hEB, 8'h90, 8'h02, 8'h02, 8'h00, 8'h00, 8'h04};
    send_frame(f); push_exp(0, 0, 16'h0060, 1, 12'hFFF, 8'd4, n_pushed - 1, 3);
    drain();

    // LEN == MAX_LEN passes the length gate; baud CMD with LEN 8 fails at EXEC.
    f = '{8'hEB, 8'h90, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00, 8'h09};
    send_frame(f); push_exp(0, 0, 16'h0060, 1, 12'hFFF, 8'd5, n_pushed - 1, 3);
    drain();

    // Loopback off.
    f = '{8'hEB, 8'h90, 8'h02, 8'h01, 8'h00, 8'h03};
    send_frame(f); push_exp(1, 0, 16'h0060, 0, 12'hFFF, 8'd5, n_pushed - 1, 3);
    drain();

    // Stall mid-frame longer than the timeout, then a full baud frame.
    f = '{8'hEB, 8'h90, 8'h01};
`ifdef RCV_CTRL_TIMEOUT_EN
    send_frame(f); push_exp(0, 0, 16'h0060, 0, 12'hFFF, 8'd6, n_pushed - 1, -1);
`else
    send_frame(f);
`endif
    repeat (TOC + 12) @(negedge clk);
    drain();
    t = n_pushed;
    f = '{8'hEB, 8'h90, 8'h01, 8'h02, 8'h12, 8'h34, 8'h49};
    send_frame(f);
`ifdef RCV_CTRL_TIMEOUT_EN
    push_exp(1, 1, 16'h1234, 0, 12'hFFF, 8'd6, n_pushed - 1, 3);
`else
    // Parser is still waiting for LEN: 0xEB is taken as LEN and rejected,
    // the rest of the frame is discarded while hunting for a header.
    push_exp(0, 0, 16'h0060, 0, 12'hFFF, 8'd6, t, 2);
`endif
    drain();

    // Reset mid-frame: everything back to reset values, tail discarded.
    f = '{8'hEB, 8'h90, 8'h01, 8'h02, 8'h00};
    send_frame(f);
    drain();
    rst_n = 1'b0;
    #1;
    check("mid_rst_baud",    32'(baud_word), 32'd0);
    check("mid_rst_mask",    32'(ch_mask),   32'hFFF);
    check("mid_rst_err_cnt", 32'(err_cnt),   32'd0);
    check("mid_rst_ren",     32'(rx_fifo_ren), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    f = '{8'h60, 8'h63};
    send_frame(f);
    drain();
    check("after_rst_baud",    32'(baud_word), 32'd0);
    check("after_rst_err_cnt", 32'(err_cnt),   32'd0);
    check("after_rst_latch",   32'(latch_baud), 32'd0);

    // err_cnt saturates at 255.
    for (int i = 0; i < 260; i++) begin
      ec = (i >= 254) ? 8'd255 : 8'(i + 1);
      f = '{8'hEB, 8'h90, 8'h03, 8'h09};
      send_frame(f); push_exp(0, 0, 16'h0000, 0, 12'hFFF, ec, n_pushed - 1, 2);
    end
    drain();
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
